alu_seq_core: RTL and testbench



---
 rtl/alu_seq_core.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// Sequential ALU: add/sub/carry ops, logic ops and an optional shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier; otherwise OP=111 yields zero via the EXEC path.
module alu_seq_core #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       OP,
   input  logic             START,
   input  logic             FI,
   input  logic             E0,
   output logic [WIDTH-1:0] BUS,
   output logic             BUS_OE,
   output logic             BUSY,
   output logic             DONE,
   output logic             CF,
   output logic             ZF,
   output logic             NF,
   output logic             VF
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic             r_cin;
   logic [WIDTH-1:0] r_res;
   logic [3:0]       r_flags;  // {C, Z, N, V}
   logic [3:0]       r_pend;
   logic             r_busy;
   logic             r_done;

   logic             w_sub;
   logic             w_cin;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_cf;
   logic             w_vf;
   logic [3:0]       w_pend_exec;

   // Subtract-type ops (001, 011) add the inverted B operand.
   assign w_sub   = ~r_op[2] & r_op[0];
   assign w_b_eff = w_sub ? ~r_b : r_b;
   assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

   always_comb begin
      w_cin = 1'b0;
      unique case (r_op[1:0])
         2'b00:   w_cin = 1'b0;
         2'b01:   w_cin = 1'b1;
         default: w_cin = r_cin;
      endcase
   end

   always_comb begin
      w_res = '0;
      w_cf  = 1'b0;
      w_vf  = 1'b0;
      case (r_op)
         3'b000, 3'b001, 3'b010, 3'b011: begin
            w_res = w_sum[WIDTH-1:0];
            w_cf  = w_sum[WIDTH];
            w_vf  = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         3'b100:  w_res = r_a & r_b;
         3'b101:  w_res = r_a | r_b;
         3'b110:  w_res = r_a ^ r_b;
         default: w_res = '0;
      endcase
   end

   assign w_pend_exec = {w_cf, (w_res == '0), w_res[WIDTH-1], w_vf};

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CntW-1:0]    r_cnt;

   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [CntW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0]   w_mul_lo;
   logic [3:0]         w_pend_mul;

   assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_cnt_nxt  = r_cnt - CntW'(1);
   assign w_mul_lo   = w_acc_nxt[WIDTH-1:0];
   assign w_pend_mul = {(w_acc_nxt[2*WIDTH-1:WIDTH] != '0), (w_mul_lo == '0),
                        w_mul_lo[WIDTH-1], 1'b0};
`endif

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state  <= StIdle;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_cin    <= 1'b0;
         r_res    <= '0;
         r_flags  <= '0;
         r_pend   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef ALU_MUL_EN
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (START) begin
                  r_a    <= A;
                  r_b    <= B;
                  r_op   <= OP;
                  r_cin  <= r_flags[3];
                  r_busy <= 1'b1;
`ifdef ALU_MUL_EN
                  if (OP == 3'b111) begin
                     r_state  <= StMul;
                     r_acc    <= '0;
                     r_mcand  <= {{WIDTH{1'b0}}, A};
                     r_mplier <= B;
                     r_cnt    <= CntW'(WIDTH);
                  end else begin
                     r_state  <= StExec;
                  end
`else
                  r_state <= StExec;
`endif
               end
            end
            StExec: begin
               r_res   <= w_res;
               r_pend  <= w_pend_exec;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= StDone;
            end
`ifdef ALU_MUL_EN
            StMul: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= w_cnt_nxt;
               if (w_cnt_nxt == '0) begin
                  r_res   <= w_mul_lo;
                  r_pend  <= w_pend_mul;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end
            end
`endif
            StDone: begin
               if (!FI) begin
                  r_flags <= r_pend;
               end
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign BUS    = E0 ? '0 : r_res;
   assign BUS_OE = ~E0;
   assign BUSY   = r_busy;
   assign DONE   = r_done;
   assign CF     = r_flags[3];
   assign ZF     = r_flags[2];
   assign NF     = r_flags[1];
   assign VF     = r_flags[0];

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed, table-driven bench for alu_seq_core at WIDTH=8 and WIDTH=16.
// Expectations follow ALU_MUL_EN when it is defined for the build.
module tb_alu_seq_core;

   logic       clk = 1'b0;
   logic       clr;
   logic [7:0] a, b;
   logic [2:0] op;
   logic       start, fi, e0;
   logic [7:0] bus;
   logic       bus_oe, busy, done, cf, zf, nf, vf;

   logic [15:0] a16, b16;
   logic [2:0]  op16;
   logic        start16, fi16, e0_16;
   logic [15:0] bus16;
   logic        bus_oe16, busy16, done16, cf16, zf16, nf16, vf16;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_seq_core #(.WIDTH(8)) u_dut8 (
      .CLK(clk), .CLR(clr), .A(a), .B(b), .OP(op), .START(start), .FI(fi), .E0(e0),
      .BUS(bus), .BUS_OE(bus_oe), .BUSY(busy), .DONE(done),
      .CF(cf), .ZF(zf), .NF(nf), .VF(vf)
   );

   alu_seq_core #(.WIDTH(16)) u_dut16 (
      .CLK(clk), .CLR(clr), .A(a16), .B(b16), .OP(op16), .START(start16), .FI(fi16),
      .E0(e0_16), .BUS(bus16), .BUS_OE(bus_oe16), .BUSY(busy16), .DONE(done16),
      .CF(cf16), .ZF(zf16), .NF(nf16), .VF(vf16)
   );

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       fi;
      logic [7:0] r;
      logic [3:0] fl;  // {C, Z, N, V}
      int         lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at posedge+1; returns DONE cycle (0 on timeout) and number of BUSY cycles.
   task automatic run8(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic fiv, output int lat, output int bsy);
      a = av; b = bv; op = o; fi = fiv; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat = 0; bsy = 0;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         if (done) lat = n;
         else begin
            if (busy) bsy++;
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic run16(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                        output int lat);
      a16 = av; b16 = bv; op16 = o; fi16 = 1'b0; start16 = 1'b1;
      @(posedge clk); #1 start16 = 1'b0;
      lat = 0;
      for (int n = 1; n <= 60 && lat == 0; n++) begin
         if (done16) lat = n;
         else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bsy;
      logic seen_done;

      vecs[0]  = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100, 2};
      vecs[1]  = '{3'b001, 8'h50, 8'h70, 1'b0, 8'hE0, 4'b0010, 2};
      vecs[2]  = '{3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, 2};
      vecs[3]  = '{3'b001, 8'h05, 8'h03, 1'b0, 8'h02, 4'b1000, 2};
      vecs[4]  = '{3'b010, 8'h10, 8'h20, 1'b1, 8'h31, 4'b1000, 2};
      vecs[5]  = '{3'b010, 8'h10, 8'h20, 1'b0, 8'h31, 4'b0000, 2};
      vecs[6]  = '{3'b011, 8'h10, 8'h20, 1'b0, 8'hEF, 4'b0010, 2};
      vecs[7]  = '{3'b100, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 2};
      vecs[8]  = '{3'b101, 8'h80, 8'h01, 1'b0, 8'h81, 4'b0010, 2};
      vecs[9]  = '{3'b110, 8'h5A, 8'h5A, 1'b0, 8'h00, 4'b0100, 2};
`ifdef ALU_MUL_EN
      vecs[10] = '{3'b111, 8'h0F, 8'h11, 1'b0, 8'hFF, 4'b0010, 9};
      vecs[11] = '{3'b111, 8'h10, 8'h10, 1'b0, 8'h00, 4'b1100, 9};
`else
      vecs[10] = '{3'b111, 8'h0F, 8'h11, 1'b0, 8'h00, 4'b0100, 2};
      vecs[11] = '{3'b111, 8'h10, 8'h10, 1'b0, 8'h00, 4'b0100, 2};
`endif
      vecs[12] = '{3'b000, 8'h80, 8'h80, 1'b0, 8'h00, 4'b1101, 2};
      vecs[13] = '{3'b011, 8'h20, 8'h10, 1'b0, 8'h10, 4'b1000, 2};

      clr = 1'b1; start = 1'b0; fi = 1'b1; e0 = 1'b1; a = '0; b = '0; op = '0;
      start16 = 1'b0; fi16 = 1'b1; e0_16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_flags", {cf, zf, nf, vf}, 0);
      chk("rst_bus_e0hi", bus, 0);
      chk("rst_bus_oe", bus_oe, 0);
      e0 = 1'b0; #1;
      chk("rst_bus_e0lo", bus, 0);
      chk("rst_bus_oe_lo", bus_oe, 1);
      e0 = 1'b1;
      clr = 1'b0;

      foreach (vecs[i]) begin
         run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fi, lat, bsy);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_busy_cycles", i), bsy, vecs[i].lat - 1);
         chk($sformatf("v%0d_done_low", i), done, 0);
         chk($sformatf("v%0d_flags", i), {cf, zf, nf, vf}, vecs[i].fl);
         e0 = 1'b0; #1;
         chk($sformatf("v%0d_result", i), bus, vecs[i].r);
         e0 = 1'b1; #1;
         chk($sformatf("v%0d_bus_off", i), bus, 0);
      end

      // START while busy must be dropped.
      a = 8'h01; b = 8'h02; op = 3'b000; fi = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 8'hAA; b = 8'h55; op = 3'b110;
      @(posedge clk); #1 start = 1'b0;
      chk("ign_done_pulse", done, 1);
      seen_done = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done || busy) seen_done = 1'b1;
      end
      chk("ign_no_second_op", seen_done, 0);
      e0 = 1'b0; #1;
      chk("ign_result", bus, 8'h03);
      e0 = 1'b1;

      // Abort mid-operation with CLR.
      run8(3'b000, 8'hFF, 8'h02, 1'b0, lat, bsy);
      chk("pre_abort_flags", {cf, zf, nf, vf}, 4'b1000);
`ifdef ALU_MUL_EN
      a = 8'h0F; b = 8'h11; op = 3'b111; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
`else
      a = 8'h01; b = 8'h01; op = 3'b000; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
`endif
      chk("abort_busy_before", busy, 1);
      clr = 1'b1; #1;
      chk("abort_busy", busy, 0);
      chk("abort_flags", {cf, zf, nf, vf}, 0);
      e0 = 1'b0; #1;
      chk("abort_result", bus, 0);
      e0 = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      seen_done = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      chk("abort_no_done", seen_done, 0);
      run8(3'b000, 8'h01, 8'h01, 1'b0, lat, bsy);
      chk("post_abort_latency", lat, 2);
      e0 = 1'b0; #1;
      chk("post_abort_result", bus, 8'h02);
      e0 = 1'b1;

      // WIDTH=16 instance.
      run16(3'b000, 16'hFFFF, 16'h0001, lat);
      chk("w16_add_latency", lat, 2);
      chk("w16_add_result", bus16, 16'h0000);
      chk("w16_add_flags", {cf16, zf16, nf16, vf16}, 4'b1100);
      run16(3'b111, 16'h0100, 16'h0100, lat);
`ifdef ALU_MUL_EN
      chk("w16_mul_latency", lat, 17);
      chk("w16_mul_flags", {cf16, zf16, nf16, vf16}, 4'b1100);
`else
      chk("w16_mul_latency", lat, 2);
      chk("w16_mul_flags", {cf16, zf16, nf16, vf16}, 4'b0100);
`endif
      chk("w16_mul_result", bus16, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
